carregador_tempo: RTL
=====================

// Module: carregador_tempo
// PURPOSE
//  Keypad-side writer for contador_nivel2: collects decimal key presses into a
//  M:SS time value (MINS, TENS, ONES BCD digits), then drives the counter's
//  parallel load (data digits + loadn) and issues a one-cycle start strobe.
//  Tracks the running countdown and returns to idle on zero or user cancel.
// PARAMETERS
//  MAX_DIGITS  3      digits accepted per entry (MINS:TENS:ONES)
//  MAX_TENS    5      largest legal value for the TENS-of-seconds digit
//  KEY_CLEAR   4'hA   key_code meaning clear / cancel
//  KEY_START   4'hB   key_code meaning start
// PORTS
//  clk         in   1  single clock, all logic on rising edge
//  clrn        in   1  synchronous active-low reset
//  key_valid   in   1  one-cycle strobe, key_code valid this cycle
//  key_code    in   4  0-9 digit, KEY_CLEAR, KEY_START; C-F illegal
//  zero        in   1  counter reports 0:00 (contador_nivel2 zero output)
//  data_mins   out  4  BCD minutes digit to counter
//  data_tens   out  4  BCD tens-of-seconds digit to counter
//  data_ones   out  4  BCD ones-of-seconds digit to counter
//  loadn       out  1  active-low parallel-load pulse to counter
//  start       out  1  one-cycle pulse: counter/magnetron enable may rise
//  cancel      out  1  one-cycle pulse: user aborted a running countdown
//  key_err     out  1  one-cycle pulse: key rejected
//  n_digits    out  2  digits currently entered (0..3)
// BEHAVIOUR
//  Reset (clrn=0 at edge): state VAZIO, digits 0, n_digits 0, loadn 1,
//   start/cancel/key_err 0. Reset wins over every other input, any state.
//  States: VAZIO, ENTRADA, CARGA, INICIO, ESPERA.
//  Digit key (VAZIO/ENTRADA): shift left, ONES<-key, TENS<-ONES, MINS<-TENS,
//   n_digits+1, state ENTRADA; visible on data_* next cycle.
//   Reject (key_err, no change) if n_digits==MAX_DIGITS or old ONES>MAX_TENS.
//  KEY_CLEAR in VAZIO/ENTRADA: digits 0, n_digits 0, state VAZIO; no key_err.
//  KEY_START in ENTRADA with value!=0:00 -> CARGA. Value 0:00 or state VAZIO:
//   key_err, no change.
//  CARGA: loadn=0 exactly one cycle, data_* stable; -> INICIO.
//  INICIO: start=1 exactly one cycle; -> ESPERA. Latency KEY_START strobe to
//   loadn low = 1 cycle, to start high = 2 cycles.
//  ESPERA: zero==1 -> VAZIO, digits cleared, n_digits 0. KEY_CLEAR -> cancel=1
//   one cycle, then VAZIO cleared. If zero and KEY_CLEAR coincide, zero wins
//   (no cancel). Other keys in ESPERA: key_err.
//  Any key_valid during CARGA or INICIO: ignored silently (no key_err).
//  Illegal codes C-F in any accepting state: key_err, no change.
//  key_valid low: no action; key_code don't-care.
//  Outputs registered; data_* hold value through CARGA/INICIO/ESPERA.
// STRUCTURE
//  Shared package/include: state encodings, KEY_CLEAR/KEY_START, BCD width 4.
//  One sub-module natural: registrador_digitos (3x4-bit BCD shift register with
//   shift/clear enables, n_digits counter); FSM and pulse logic in top.
// TESTING
//  Keys 1,3,0,START -> data 1:30, loadn low cycle+1, start high cycle+2, one each.
//  Keys 9,5 -> 0:95? no: 9 then 5 rejected? 9 accepted, 5 -> key_err (ONES=9>5).
//  Keys 2,4,5,7 -> 4th key key_err, data stays 2:45, n_digits=3.
//  START in VAZIO and 0,0,START -> key_err both, loadn never low.
//  1,0,START, run, KEY_CLEAR in ESPERA -> cancel pulse, then data 0:00, VAZIO.
//  Same run, zero=1 with KEY_CLEAR same cycle -> VAZIO, cancel stays 0;
//   clrn=0 during CARGA -> loadn back to 1 next edge, all outputs reset.

Source files
------------

// File: rtl/carregador_tempo_pkg.sv
// carregador_tempo_pkg: shared constants, key codes and FSM state encoding
// for the keypad-side time loader.
package carregador_tempo_pkg;
   localparam int BCD_W      = 4;
   localparam int MAX_DIGITS = 3;
   localparam int MAX_TENS   = 5;
   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_START = 4'hB;
   typedef enum logic [2:0] {VAZIO, ENTRADA, CARGA, INICIO, ESPERA} state_t;
   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction
endpackage

// File: rtl/carregador_tempo_registrador_digitos.sv
// registrador_digitos: 3-digit BCD shift register (MINS:TENS:ONES) with
// clear priority over shift, plus a count of digits entered.
module registrador_digitos
   import carregador_tempo_pkg::*;
(
   input  logic             clk,
   input  logic             clrn,
   input  logic             i_shift,
   input  logic             i_clear,
   input  logic [BCD_W-1:0] i_digit,
   output logic [BCD_W-1:0] o_mins,
   output logic [BCD_W-1:0] o_tens,
   output logic [BCD_W-1:0] o_ones,
   output logic [1:0]       o_n_digits
);
   logic [BCD_W-1:0] r_mins, r_tens, r_ones;
   logic [1:0]       r_n;
   always_ff @(posedge clk) begin
      if (!clrn || i_clear) begin
         r_mins <= '0;
         r_tens <= '0;
         r_ones <= '0;
         r_n    <= '0;
      end else if (i_shift) begin
         r_mins <= r_tens;
         r_tens <= r_ones;
         r_ones <= i_digit;
         r_n    <= r_n + 2'd1;
      end
   end
   assign o_mins     = r_mins;
   assign o_tens     = r_tens;
   assign o_ones     = r_ones;
   assign o_n_digits = r_n;
endmodule

// File: rtl/carregador_tempo.sv
// carregador_tempo: collects keypad digits into M:SS, drives the counter's
// parallel load and start strobe, and tracks the countdown until zero/cancel.
module carregador_tempo
   import carregador_tempo_pkg::*;
(
   input  logic       clk,
   input  logic       clrn,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       zero,
   output logic [3:0] data_mins,
   output logic [3:0] data_tens,
   output logic [3:0] data_ones,
   output logic       loadn,
   output logic       start,
   output logic       cancel,
   output logic       key_err,
   output logic [1:0] n_digits
);
   state_t r_state;
   logic   r_loadn, r_start, r_cancel, r_key_err;
   logic   w_entry, w_is_clear, w_is_start, w_is_digit, w_shift, w_go;
   logic   w_esp_zero, w_esp_cancel, w_clear, w_err;
   assign w_entry      = (r_state == VAZIO) || (r_state == ENTRADA);
   assign w_is_clear   = key_valid && (key_code == KEY_CLEAR);
   assign w_is_start   = key_valid && (key_code == KEY_START);
   assign w_is_digit   = key_valid && is_digit(key_code);
   // a new digit is refused once the buffer is full or when shifting would
   // push an illegal value (>5) into the tens-of-seconds position
   assign w_shift      = w_entry && w_is_digit && (n_digits != 2'(MAX_DIGITS))
                         && (data_ones <= 4'(MAX_TENS));
   assign w_go         = (r_state == ENTRADA) && w_is_start && (|{data_mins, data_tens, data_ones});
   assign w_esp_zero   = (r_state == ESPERA) && zero;
   assign w_esp_cancel = (r_state == ESPERA) && !zero && w_is_clear;
   assign w_clear      = (w_entry && w_is_clear) || w_esp_zero || w_esp_cancel;
   assign w_err        = key_valid && !w_esp_zero &&
                         ((w_entry && !w_shift && !w_is_clear && !w_go) ||
                          ((r_state == ESPERA) && !w_is_clear));
   registrador_digitos u_digitos (
      .clk        (clk),
      .clrn       (clrn),
      .i_shift    (w_shift),
      .i_clear    (w_clear),
      .i_digit    (key_code),
      .o_mins     (data_mins),
      .o_tens     (data_tens),
      .o_ones     (data_ones),
      .o_n_digits (n_digits)
   );
   always_ff @(posedge clk) begin
      if (!clrn) begin
         r_state   <= VAZIO;
         r_loadn   <= 1'b1;
         r_start   <= 1'b0;
         r_cancel  <= 1'b0;
         r_key_err <= 1'b0;
      end else begin
         r_loadn   <= !w_go;
         r_start   <= (r_state == CARGA);
         r_cancel  <= w_esp_cancel;
         r_key_err <= w_err;
         case (r_state)
            VAZIO, ENTRADA: r_state <= w_go ? CARGA : w_is_clear ? VAZIO : w_shift ? ENTRADA : r_state;
            CARGA:          r_state <= INICIO;
            INICIO:         r_state <= ESPERA;
            ESPERA:         r_state <= (zero || w_is_clear) ? VAZIO : ESPERA;
            default:        r_state <= VAZIO;
         endcase
      end
   end
   assign loadn   = r_loadn;
   assign start   = r_start;
   assign cancel  = r_cancel;
   assign key_err = r_key_err;
endmodule
